// File: rtl/rs_ctrl_pkg.sv
// Shared constants for the RS decode controller. It holds the host command
// code, the status codes, the FSM state encoding and a status classification
// helper.
package rs_ctrl_pkg;

   localparam logic [7:0] CMD_DECODE = 8'h01;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_FAIL    = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'hE1;
   localparam logic [7:0] ST_BAD_CMD = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_HDR   = 3'd4,
      S_DATA  = 3'd5
   } state_t;

   // The message payload follows the status byte only when the decoder ran to completion.
   function automatic logic status_has_data(input logic [7:0] st);
      return (st == ST_OK) || (st == ST_FAIL);
   endfunction

endpackage

// File: rtl/rs_decode_ctrl.sv
// UART-facing controller for an external Reed-Solomon decoder.
// It receives a command byte and a codeword over rx, writes the codeword into
// the external buffer and starts the decoder. While the decode is in progress
// it holds the scope trigger high. When the decode ends it returns a status
// byte and, when the decode ran to completion, the decoded message over tx.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   rx_data/rx_valid    : incoming UART bytes (one-cycle strobe)
//   tx_data/tx_valid/tx_ready : outgoing bytes, valid/ready handshake
//   cw_we/cw_addr/cw_wdata    : codeword buffer write port
//   dec_start/dec_done/dec_fail : decoder control and completion
//   msg_addr/msg_rdata  : message buffer read port (one-cycle latency)
//   trig                : high while a decode is in progress
module rs_decode_ctrl
   import rs_ctrl_pkg::*;
#(
   parameter int unsigned CW_BYTES  = 46,
   parameter int unsigned MSG_BYTES = 16,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         cw_we,
   output logic [$clog2(CW_BYTES)-1:0]  cw_addr,
   output logic [7:0]                   cw_wdata,
   output logic                         dec_start,
   input  logic                         dec_done,
   input  logic                         dec_fail,
   output logic [$clog2(MSG_BYTES)-1:0] msg_addr,
   input  logic [7:0]                   msg_rdata,
   output logic                         trig
);

   localparam int unsigned CW_AW  = $clog2(CW_BYTES);
   localparam int unsigned MSG_AW = $clog2(MSG_BYTES);
   localparam int unsigned MC_W   = $clog2(MSG_BYTES + 1);
   localparam int unsigned CYC_W  = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [CW_AW-1:0]   byte_cnt;
   logic [CYC_W-1:0]   cyc_cnt;
   logic [MC_W-1:0]    msg_cnt;   // message bytes loaded into tx_data so far
   logic               fetch;     // DATA is waiting to latch msg_rdata
   logic [7:0]         status;
   logic               timeout_c;

   // The counter has sat in WAIT for TIMEOUT cycles once this cycle completes.
   assign timeout_c = (cyc_cnt >= CYC_W'(TIMEOUT - 1));

   // Control FSM. All outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         byte_cnt  <= '0;
         cyc_cnt   <= '0;
         msg_cnt   <= '0;
         fetch     <= 1'b0;
         status    <= ST_OK;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         cw_we     <= 1'b0;
         cw_addr   <= '0;
         cw_wdata  <= 8'h00;
         dec_start <= 1'b0;
         msg_addr  <= '0;
         trig      <= 1'b0;
      end else begin
         cw_we     <= 1'b0;
         dec_start <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  if (rx_data == CMD_DECODE) begin
                     byte_cnt <= '0;
                     state    <= S_LOAD;
                  end else begin
                     status   <= ST_BAD_CMD;
                     tx_data  <= ST_BAD_CMD;
                     tx_valid <= 1'b1;
                     msg_addr <= '0;
                     state    <= S_HDR;
                  end
               end
            end

            S_LOAD: begin
               if (rx_valid) begin
                  cw_we    <= 1'b1;
                  cw_addr  <= byte_cnt;
                  cw_wdata <= rx_data;
                  if (byte_cnt == CW_AW'(CW_BYTES - 1)) begin
                     byte_cnt <= '0;
                     state    <= S_START;
                  end else begin
                     byte_cnt <= byte_cnt + CW_AW'(1);
                  end
               end
            end

            S_START: begin
               dec_start <= 1'b1;
               trig      <= 1'b1;
               cyc_cnt   <= '0;
               state     <= S_WAIT;
            end

            // A completion from the decoder takes priority over a timeout that expires in the same cycle.
            S_WAIT: begin
               if (dec_done) begin
                  trig     <= 1'b0;
                  status   <= dec_fail ? ST_FAIL : ST_OK;
                  tx_data  <= dec_fail ? ST_FAIL : ST_OK;
                  tx_valid <= 1'b1;
                  msg_addr <= '0;
                  state    <= S_HDR;
               end else if (timeout_c) begin
                  trig     <= 1'b0;
                  status   <= ST_TIMEOUT;
                  tx_data  <= ST_TIMEOUT;
                  tx_valid <= 1'b1;
                  msg_addr <= '0;
                  state    <= S_HDR;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end

            // msg_addr has held 0 since HDR was entered, so byte 0 is ready when DATA fetches it.
            S_HDR: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  if (status_has_data(status)) begin
                     msg_cnt <= '0;
                     fetch   <= 1'b1;
                     state   <= S_DATA;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            // The next address is issued when a byte is loaded. At least two edges
            // then pass before the following fetch, which covers the read latency.
            S_DATA: begin
               if (fetch) begin
                  tx_data  <= msg_rdata;
                  tx_valid <= 1'b1;
                  fetch    <= 1'b0;
                  msg_cnt  <= msg_cnt + MC_W'(1);
                  if (msg_cnt != MC_W'(MSG_BYTES - 1))
                     msg_addr <= msg_addr + MSG_AW'(1);
               end else if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  if (msg_cnt == MC_W'(MSG_BYTES)) begin
                     msg_cnt  <= '0;
                     msg_addr <= '0;
                     state    <= S_IDLE;
                  end else begin
                     fetch <= 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_decode_ctrl.sv
// Directed self-checking bench for rs_decode_ctrl (TIMEOUT shortened to 200).
module tb_rs_decode_ctrl;
   import rs_ctrl_pkg::*;

   localparam int unsigned CW_BYTES  = 46;
   localparam int unsigned MSG_BYTES = 16;
   localparam int unsigned TIMEOUT   = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       cw_we;
   logic [5:0] cw_addr;
   logic [7:0] cw_wdata;
   logic       dec_start;
   logic       dec_done;
   logic       dec_fail;
   logic [3:0] msg_addr;
   logic [7:0] msg_rdata;
   logic       trig;

   int checks = 0;
   int errors = 0;

   rs_decode_ctrl #(
      .CW_BYTES (CW_BYTES),
      .MSG_BYTES(MSG_BYTES),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .cw_we    (cw_we),
      .cw_addr  (cw_addr),
      .cw_wdata (cw_wdata),
      .dec_start(dec_start),
      .dec_done (dec_done),
      .dec_fail (dec_fail),
      .msg_addr (msg_addr),
      .msg_rdata(msg_rdata),
      .trig     (trig)
   );

   always #5 clk = ~clk;

   // Message buffer model with a registered read.
   function automatic logic [7:0] msg_byte(input int i);
      return 8'(8'h80 + 3 * i);
   endfunction

   always @(posedge clk) msg_rdata <= msg_byte(int'(msg_addr));

   // Output monitors
   logic [7:0] tx_q[$];
   logic [5:0] cw_a_q[$];
   logic [7:0] cw_d_q[$];
   int trig_cycles = 0;
   int start_cnt   = 0;

   always @(posedge clk) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (cw_we) begin
         cw_a_q.push_back(cw_addr);
         cw_d_q.push_back(cw_wdata);
      end
      if (trig) trig_cycles++;
      if (dec_start) start_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      tx_q.delete();
      cw_a_q.delete();
      cw_d_q.delete();
      trig_cycles = 0;
      start_cnt   = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int nbytes);
      send_byte(CMD_DECODE);
      for (int i = 0; i < nbytes; i++) send_byte(8'(i));
   endtask

   task automatic wait_tx(input int n);
      int c;
      c = 0;
      while (tx_q.size() < n && c < 600) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic wait_start(input string tag);
      int c;
      c = 0;
      while (!dec_start && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_start_seen"}, 32'(dec_start), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
      chk({tag, "_tx_data"},   32'(tx_data),   32'h00);
      chk({tag, "_cw_we"},     32'(cw_we),     32'd0);
      chk({tag, "_cw_addr"},   32'(cw_addr),   32'd0);
      chk({tag, "_dec_start"}, 32'(dec_start), 32'd0);
      chk({tag, "_trig"},      32'(trig),      32'd0);
      chk({tag, "_msg_addr"},  32'(msg_addr),  32'd0);
      chk({tag, "_state"},     32'(dut.state), 32'(S_IDLE));
   endtask

   // Full decode: dec_done arrives 100 cycles after dec_start.
   task automatic run_decode(input logic fail, input bit stall, input string tag);
      int bad;
      int idx;
      logic [7:0] held;
      clear_logs();
      send_frame(CW_BYTES);
      wait_start(tag);
      repeat (100) @(posedge clk);
      #1 dec_done = 1'b1; dec_fail = fail;
      @(posedge clk);
      #1 dec_done = 1'b0; dec_fail = 1'b0;

      if (stall) begin
         wait_tx(5);
         idx = 0;
         while (!tx_valid && idx < 10) begin
            @(negedge clk);
            idx++;
         end
         tx_ready = 1'b0;
         held = tx_data;
         idx  = tx_q.size();
         chk({tag, "_stall_byte"}, 32'(held), 32'(msg_byte(idx - 1)));
         bad = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== held) bad++;
         end
         chk({tag, "_stall_stable"}, 32'(bad), 32'd0);
         chk({tag, "_stall_no_accept"}, 32'(tx_q.size()), 32'(idx));
         tx_ready = 1'b1;
      end

      wait_tx(1 + MSG_BYTES);
      repeat (6) @(negedge clk);

      chk({tag, "_cw_count"}, 32'(cw_a_q.size()), 32'(CW_BYTES));
      bad = 0;
      for (int i = 0; i < cw_a_q.size(); i++)
         if (cw_a_q[i] !== 6'(i) || cw_d_q[i] !== 8'(i)) bad++;
      chk({tag, "_cw_content"}, 32'(bad), 32'd0);
      chk({tag, "_start_pulses"}, 32'(start_cnt), 32'd1);
      chk({tag, "_trig_cycles"}, 32'(trig_cycles), 32'd101);
      chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'(1 + MSG_BYTES));
      if (tx_q.size() == 1 + MSG_BYTES) begin
         chk({tag, "_status"}, 32'(tx_q[0]), fail ? 32'(ST_FAIL) : 32'(ST_OK));
         bad = 0;
         for (int i = 0; i < MSG_BYTES; i++)
            if (tx_q[1 + i] !== msg_byte(i)) bad++;
         chk({tag, "_msg_bytes"}, 32'(bad), 32'd0);
      end
      chk({tag, "_end_state"}, 32'(dut.state), 32'(S_IDLE));
      chk({tag, "_end_tx_valid"}, 32'(tx_valid), 32'd0);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      dec_done = 1'b0;
      dec_fail = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Successful decode
      run_decode(1'b0, 1'b0, "ok");

      // Uncorrectable decode
      run_decode(1'b1, 1'b0, "fail");

      // Timeout. rx bytes during WAIT are dropped.
      clear_logs();
      send_frame(CW_BYTES);
      wait_start("tmo");
      send_byte(CMD_DECODE);
      send_byte(8'h7F);
      wait_tx(1);
      repeat (40) @(negedge clk);
      chk("tmo_trig_cycles", 32'(trig_cycles), 32'(TIMEOUT));
      chk("tmo_tx_count", 32'(tx_q.size()), 32'd1);
      if (tx_q.size() > 0) chk("tmo_status", 32'(tx_q[0]), 32'(ST_TIMEOUT));
      chk("tmo_cw_count", 32'(cw_a_q.size()), 32'(CW_BYTES));
      chk("tmo_state", 32'(dut.state), 32'(S_IDLE));
      // A late dec_done in IDLE is ignored.
      @(posedge clk); #1 dec_done = 1'b1;
      @(posedge clk); #1 dec_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("late_done_state", 32'(dut.state), 32'(S_IDLE));
      chk("late_done_tx", 32'(tx_q.size()), 32'd1);

      // Unknown command
      clear_logs();
      send_byte(8'h7F);
      wait_tx(1);
      repeat (10) @(negedge clk);
      chk("badcmd_tx_count", 32'(tx_q.size()), 32'd1);
      if (tx_q.size() > 0) chk("badcmd_status", 32'(tx_q[0]), 32'(ST_BAD_CMD));
      chk("badcmd_cw_we", 32'(cw_a_q.size()), 32'd0);
      chk("badcmd_start", 32'(start_cnt), 32'd0);
      chk("badcmd_state", 32'(dut.state), 32'(S_IDLE));

      // tx_ready stalled during DATA
      run_decode(1'b0, 1'b1, "stall");

      // Reset in the middle of LOAD, then a stray dec_done
      clear_logs();
      send_frame(20);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      chk("midrst_cw_count", 32'(cw_a_q.size()), 32'd20);
      @(posedge clk); #1 dec_done = 1'b1;
      @(posedge clk); #1 dec_done = 1'b0;
      repeat (60) @(negedge clk);
      chk("midrst_start", 32'(start_cnt), 32'd0);
      chk("midrst_tx", 32'(tx_q.size()), 32'd0);
      chk("midrst_state", 32'(dut.state), 32'(S_IDLE));

      // A fresh decode after the reset
      run_decode(1'b0, 1'b0, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_decode_ctrl.md
RS_DECODE_CTRL -- requirements
Module: rs_decode_ctrl

Interface
REQ-001 SHALL have parameter CW_BYTES, default 46, codeword length in bytes (HQC-128 n1).
REQ-002 SHALL have parameter MSG_BYTES, default 16, decoded message length in bytes (k).
REQ-003 SHALL have parameter TIMEOUT, default 65535, maximum decode cycles before abort.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8, received UART byte.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe marking rx_data valid.
REQ-008 SHALL have port tx_data, output, 8, byte to transmit.
REQ-009 SHALL have port tx_valid, output, 1, tx_data valid; held until accepted.
REQ-010 SHALL have port tx_ready, input, 1, transmitter accepts byte when tx_valid&&tx_ready.
REQ-011 SHALL have port cw_we, output, 1, codeword buffer write enable.
REQ-012 SHALL have port cw_addr, output, $clog2(CW_BYTES), codeword buffer write address.
REQ-013 SHALL have port cw_wdata, output, 8, codeword buffer write data.
REQ-014 SHALL have port dec_start, output, 1, one-cycle decoder start pulse.
REQ-015 SHALL have port dec_done, input, 1, one-cycle decoder completion pulse.
REQ-016 SHALL have port dec_fail, input, 1, decoder uncorrectable flag, valid with dec_done.
REQ-017 SHALL have port msg_addr, output, $clog2(MSG_BYTES), message buffer read address.
REQ-018 SHALL have port msg_rdata, input, 8, message byte; one-cycle read latency after msg_addr.
REQ-019 SHALL have port trig, output, 1, scope trigger, high exactly while decode in progress.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, START, WAIT, HDR, DATA.
REQ-021 IDLE: on rx_valid with rx_data=0x01 SHALL go LOAD with byte counter 0; with any other byte SHALL emit status 0xEE via HDR then return IDLE, no data.
REQ-022 LOAD: each rx_valid SHALL write rx_data to cw_addr=counter (cw_we same cycle as rx_valid registered, one-cycle latency), counter++; after write CW_BYTES-1 SHALL go START.
REQ-023 START: SHALL pulse dec_start for one cycle, set trig, clear cycle counter, go WAIT.
REQ-024 WAIT: trig high; on dec_done SHALL clear trig next cycle, latch status 0x00 (ok) or 0x01 (dec_fail), go HDR.
REQ-025 WAIT: if cycle counter reaches TIMEOUT without dec_done, SHALL clear trig, latch status 0xE1, go HDR; no message bytes sent.
REQ-026 HDR: SHALL present latched status on tx_data with tx_valid until handshake; then go DATA if status 0x00 or 0x01, else IDLE.
REQ-027 DATA: SHALL send MSG_BYTES bytes in ascending address order, prefetching msg_addr so tx_valid never shows stale data; after last handshake go IDLE.
REQ-028 rx_valid outside IDLE/LOAD SHALL be ignored (dropped, no state change).
REQ-029 dec_done outside WAIT SHALL be ignored.
REQ-030 tx_valid SHALL only be asserted in HDR/DATA; tx_data SHALL be stable while tx_valid&&!tx_ready.
REQ-031 dec_done and timeout in the same cycle: dec_done SHALL win.
REQ-032 Counters SHALL be sized to hold their maximum value without wrap; TIMEOUT counter saturates.

Reset
REQ-033 rst SHALL force IDLE, all counters 0, and tx_valid, cw_we, dec_start, trig low, tx_data 0x00, cw_addr/msg_addr 0, on the next clk edge.
REQ-034 rst asserted mid-LOAD/WAIT/DATA SHALL abandon the transaction with no further output bytes; a subsequent dec_done SHALL be ignored.

Structure
REQ-035 Command code 0x01 and status codes 0x00/0x01/0xE1/0xEE SHALL be constants in shared package rs_ctrl_pkg, with the FSM state enum.
REQ-036 Single module, no sub-modules; buffers and decoder remain external.

Verification
REQ-037 0x01 + 46 bytes 0x00..0x2D, dec_done 100 cycles after dec_start, dec_fail=0 -> cw writes addr i data i, trig high exactly 101 cycles, tx 0x00 then 16 msg bytes.
REQ-038 Same with dec_fail=1 -> tx 0x01 then 16 bytes.
REQ-039 TIMEOUT=200, no dec_done -> trig falls after 200 cycles, tx single 0xE1, FSM IDLE.
REQ-040 rx byte 0x7F in IDLE -> tx single 0xEE, no cw_we, no dec_start.
REQ-041 tx_ready held low 10 cycles during DATA -> tx_data/tx_valid stable, no byte lost or duplicated.
REQ-042 rst pulsed after 20 LOAD bytes -> no dec_start, outputs at reset values; fresh 0x01 + 46 bytes then decodes normally.
